// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: scan counters plus aligned blank/sync/frame strobes.
// Optional `VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        sof,
    output logic        eof
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) ||
        (H_VISIBLE == 0) || (H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
        (V_VISIBLE == 0) || (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_param_check
        $error("vga_timing_gen: totals must be <= 1024 and every timing parameter non-zero");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] X_EOF    = 10'(H_VISIBLE - 1);
    localparam logic [9:0] Y_EOF    = 10'(V_VISIBLE - 1);

    logic [9:0] x_r;
    logic [9:0] y_r;
    logic       blank_r;
    logic       hs_r;
    logic       vs_r;
    logic       sof_r;
    logic       eof_r;

    logic [9:0] x_nxt_s;
    logic [9:0] y_nxt_s;
    logic       blank_nxt_s;
    logic       hs_act_s;
    logic       vs_act_s;
    logic       sof_nxt_s;
    logic       eof_nxt_s;

    // Next scan position: x wraps at end of line, y advances on x wrap and wraps at end of frame.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (x_r == H_LAST) begin
            x_nxt_s = 10'd0;
            if (y_r == V_LAST) begin
                y_nxt_s = 10'd0;
            end else begin
                y_nxt_s = y_r + 10'd1;
            end
        end else begin
            x_nxt_s = x_r + 10'd1;
            y_nxt_s = y_r;
        end
    end

    // Qualifiers are decoded from the next position so they land in the same register stage as it.
    always_comb begin
        blank_nxt_s = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
        hs_act_s    = (x_nxt_s >= HS_START) && (x_nxt_s < HS_END);
        vs_act_s    = (y_nxt_s >= VS_START) && (y_nxt_s < VS_END);
        sof_nxt_s   = (x_nxt_s == 10'd0) && (y_nxt_s == 10'd0);
        eof_nxt_s   = (x_nxt_s == X_EOF) && (y_nxt_s == Y_EOF);
    end

    // Counter and qualifier registers; reset forces syncs inactive at once.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_r     <= 10'd0;
            y_r     <= 10'd0;
            blank_r <= 1'b0;
            hs_r    <= ~SYNC_POL;
            vs_r    <= ~SYNC_POL;
            sof_r   <= 1'b0;
            eof_r   <= 1'b0;
        end else begin
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            blank_r <= blank_nxt_s;
            hs_r    <= hs_act_s ? SYNC_POL : ~SYNC_POL;
            vs_r    <= vs_act_s ? SYNC_POL : ~SYNC_POL;
            sof_r   <= sof_nxt_s;
            eof_r   <= eof_nxt_s;
        end
    end

    assign DrawX = x_r;
    assign DrawY = y_r;
    assign blank = blank_r;
    assign hs    = hs_r;
    assign vs    = vs_r;
    assign sof   = sof_r;
    assign eof   = eof_r;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter advances on the same edge that registers sof, wrapping naturally at 16 bits.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (sof_nxt_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench: a default-timing DUT (active-low syncs) and a
// shrunken-timing DUT (active-high syncs) checked every cycle against an arithmetic model.
module tb_vga_timing_gen;

    logic        clk;
    logic        reset;

    logic [9:0]  x_a, y_a, x_b, y_b;
    logic        blank_a, hs_a, vs_a, sof_a, eof_a;
    logic        blank_b, hs_b, vs_b, sof_b, eof_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int          n_vec;
    int          n_err;
    longint      t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        eof;
        logic [15:0] fc;
    } exp_t;

    vga_timing_gen dut_a (
        .vga_clk(clk), .reset(reset),
        .DrawX(x_a), .DrawY(y_a), .blank(blank_a), .hs(hs_a), .vs(vs_a),
        .sof(sof_a), .eof(eof_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1)
    ) dut_b (
        .vga_clk(clk), .reset(reset),
        .DrawX(x_b), .DrawY(y_b), .blank(blank_b), .hs(hs_b), .vs(vs_b),
        .sof(sof_b), .eof(eof_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // t = rising edges seen since reset release; position is plain div/mod of t.
    function automatic exp_t model(input longint tt, input int hv, input int hf, input int hsn,
                                   input int hb, input int vv, input int vf, input int vsn,
                                   input int vb, input logic pol);
        exp_t   e;
        int     ht;
        longint fr;
        longint p;
        int     x;
        int     y;
        ht = hv + hf + hsn + hb;
        fr = longint'(ht) * longint'(vv + vf + vsn + vb);
        if (tt == 0) begin
            e = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: ~pol, vs: ~pol,
                  sof: 1'b0, eof: 1'b0, fc: 16'd0};
        end else begin
            p       = tt % fr;
            x       = int'(p % ht);
            y       = int'(p / ht);
            e.x     = 10'(x);
            e.y     = 10'(y);
            e.blank = (x < hv) && (y < vv);
            e.hs    = ((x >= hv + hf) && (x < hv + hf + hsn)) ? pol : ~pol;
            e.vs    = ((y >= vv + vf) && (y < vv + vf + vsn)) ? pol : ~pol;
            e.sof   = (p == 0);
            e.eof   = (x == hv - 1) && (y == vv - 1);
            e.fc    = 16'(tt / fr);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t ea;
        exp_t eb;
        ea = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        eb = model(t, 16, 4, 6, 4, 12, 2, 2, 3, 1'b1);
        check({tag, ".a.x"},     32'(x_a),     32'(ea.x));
        check({tag, ".a.y"},     32'(y_a),     32'(ea.y));
        check({tag, ".a.blank"}, 32'(blank_a), 32'(ea.blank));
        check({tag, ".a.hs"},    32'(hs_a),    32'(ea.hs));
        check({tag, ".a.vs"},    32'(vs_a),    32'(ea.vs));
        check({tag, ".a.sof"},   32'(sof_a),   32'(ea.sof));
        check({tag, ".a.eof"},   32'(eof_a),   32'(ea.eof));
        check({tag, ".b.x"},     32'(x_b),     32'(eb.x));
        check({tag, ".b.y"},     32'(y_b),     32'(eb.y));
        check({tag, ".b.blank"}, 32'(blank_b), 32'(eb.blank));
        check({tag, ".b.hs"},    32'(hs_b),    32'(eb.hs));
        check({tag, ".b.vs"},    32'(vs_b),    32'(eb.vs));
        check({tag, ".b.sof"},   32'(sof_b),   32'(eb.sof));
        check({tag, ".b.eof"},   32'(eof_b),   32'(eb.eof));
`ifdef VGA_TIMING_FRAME_CNT_EN
        check({tag, ".a.fc"},    32'(fc_a),    32'(ea.fc));
        check({tag, ".b.fc"},    32'(fc_b),    32'(eb.fc));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) t++;
        @(negedge clk);
        check_all(tag);
    endtask

    // Called at a falling edge: assert reset between edges and check before the next rising edge.
    task automatic async_reset(input int hold);
        #2;
        reset = 1'b1;
        t     = 0;
        #1;
        check_all("async_rst");
        repeat (hold) step("in_rst");
        reset = 1'b0;
        check_all("released");
        step("first_edge");
    endtask

    initial begin
        int target;
        n_vec = 0;
        n_err = 0;
        t     = 0;
        reset = 1'b1;

        repeat (5) step("reset");
        reset = 1'b0;
        check_all("release");
        step("first_edge");
        check("first_x", 32'(x_a), 32'd1);

        // Three default lines and several small frames.
        repeat (2500) step("run");

        // Reset in the middle of an hsync pulse on the default DUT.
        target = $urandom_range(656, 751);
        for (int i = 0; i < 800 && (t % 800) != longint'(target); i++) step("seek_hs");
        check("seek_hs_reached", 32'(t % 800), 32'(target));
        check("hs_active_before_rst", 32'(hs_a), 32'd0);
        async_reset($urandom_range(1, 3));

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(50, 1500)) step("rand_run");
            async_reset($urandom_range(1, 3));
        end

        repeat (1500) step("tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
